tdc_result_reader: RTL and testbench

Read-side bus master for the external TDC chip. Once the configuration writer has initialised the chip, it is armed by the measurement controller and waits for the TDC interrupt. It then reads a fixed block of result registers over the TDC's CSN/RDN/addr/data bus. Each captured word is presented on a valid/ready stream toward the result FIFO.

---
 rtl/tdc_result_reader.sv | 179 +++++++++++++++++
 tb/tb_tdc_result_reader.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_result_reader.sv
// rtl/tdc_result_reader.sv - TDC result-register read master with valid/ready result stream (optional wait timeout: TDC_RD_TIMEOUT_EN)
module tdc_result_reader #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 28,
    parameter int RES_BASE = 0,
    parameter int NUM_RES  = 4,
    parameter int RD_PULSE = 3,
    parameter int TIMEOUT  = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              intn,
    output logic              CSN,
    output logic              RDN,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [ADDR_W-1:0] res_addr,
    output logic              busy,
    output logic              done,
    output logic              timeout
);

    localparam int IDX_W = (NUM_RES > 1) ? $clog2(NUM_RES) : 1;
    localparam int PC_W  = (RD_PULSE > 1) ? $clog2(RD_PULSE) : 1;

    // Reject parameter sets the bus sequencing cannot honour.
    if (NUM_RES < 1 || NUM_RES > 16 || RD_PULSE < 1 || TIMEOUT < 1 ||
        RES_BASE + NUM_RES - 1 >= (1 << ADDR_W)) begin : g_param_check
        $error("tdc_result_reader: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        IDLE,
        WAIT_INT,
        SETUP,
        STROBE,
        HOLD,
        OUT,
        DONE
    } state_t;

    state_t            state, state_nx;
    logic [IDX_W-1:0]  index, index_nx;
    logic [PC_W-1:0]   pcnt, pcnt_nx;
    logic              capture;
    logic              expire;
    logic              intn_m, intn_s;

    // Two-flop synchronizer for the asynchronous interrupt; idles high.
    always_ff @(posedge clk) begin
        if (reset) begin
            intn_m <= 1'b1;
            intn_s <= 1'b1;
        end else begin
            intn_m <= intn;
            intn_s <= intn_m;
        end
    end

`ifdef TDC_RD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] wcnt;

    // Interrupt wait counter: restarts whenever the FSM is outside WAIT_INT.
    always_ff @(posedge clk) begin
        if (reset || state != WAIT_INT) begin
            wcnt <= '0;
        end else begin
            wcnt <= wcnt + 1'b1;
        end
    end

    assign expire = (state == WAIT_INT) && intn_s && (wcnt == TO_W'(TIMEOUT - 1));

    // Timeout is a single-cycle pulse coincident with the return to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout <= 1'b0;
        end else begin
            timeout <= expire;
        end
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    // Next-state, word index and strobe-length sequencing.
    always_comb begin
        state_nx = state;
        index_nx = index;
        pcnt_nx  = pcnt;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (arm) begin
                    state_nx = WAIT_INT;
                    index_nx = '0;
                end
            end
            WAIT_INT: begin
                if (!intn_s) begin
                    state_nx = SETUP;
                end else if (expire) begin
                    state_nx = IDLE;
                end
            end
            SETUP: begin
                state_nx = STROBE;
                pcnt_nx  = '0;
            end
            STROBE: begin
                if (pcnt == PC_W'(RD_PULSE - 1)) begin
                    state_nx = HOLD;
                    capture  = 1'b1;
                end else begin
                    pcnt_nx = pcnt + 1'b1;
                end
            end
            HOLD: begin
                state_nx = OUT;
            end
            OUT: begin
                if (res_ready) begin
                    if (index == IDX_W'(NUM_RES - 1)) begin
                        state_nx = DONE;
                    end else begin
                        index_nx = index + 1'b1;
                        state_nx = SETUP;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State plus registered bus and stream outputs, all decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            index     <= '0;
            pcnt      <= '0;
            CSN       <= 1'b1;
            RDN       <= 1'b1;
            addr      <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            index     <= index_nx;
            pcnt      <= pcnt_nx;
            CSN       <= !(state_nx == SETUP || state_nx == STROBE);
            RDN       <= !(state_nx == STROBE);
            res_valid <= (state_nx == OUT);
            busy      <= (state_nx != IDLE);
            done      <= (state_nx == DONE);
            if (state_nx == SETUP) begin
                addr <= ADDR_W'(RES_BASE) + ADDR_W'(index_nx);
            end
            if (capture) begin
                res_data <= data_in;
                res_addr <= addr;
            end
        end
    end

endmodule

// File: tb/tb_tdc_result_reader.sv
// tb/tb_tdc_result_reader.sv - self-checking bench for tdc_result_reader
module tb_tdc_result_reader;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 28;
    localparam int RES_BASE = 0;
    localparam int NUM_RES  = 4;
    localparam int RD_PULSE = 3;
    localparam int TIMEOUT  = 1000;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              arm = 1'b0;
    logic              intn = 1'b1;
    logic              res_ready = 1'b1;
    logic [DATA_W-1:0] data_in = '0;
    logic              CSN, RDN, res_valid, busy, done, timeout;
    logic [ADDR_W-1:0] addr, res_addr;
    logic [DATA_W-1:0] res_data;

    tdc_result_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RES_BASE(RES_BASE),
        .NUM_RES(NUM_RES), .RD_PULSE(RD_PULSE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .arm(arm), .intn(intn),
        .CSN(CSN), .RDN(RDN), .addr(addr), .data_in(data_in),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_addr(res_addr), .busy(busy), .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail = 0;

    // Bus / stream observations, accumulated once per cycle just before each edge.
    int rdn_falls = 0, len_bad = 0, lead_bad = 0, ovl_bad = 0, stab_bad = 0;
    int csn_low = 0, done_cnt = 0, to_cnt = 0, rd_run = 0;
    logic p_csn = 1'b1, p2_csn = 1'b1, p_rdn = 1'b1, p_valid = 1'b0, p_ready = 1'b0;
    logic [DATA_W-1:0] p_data = '0;
    logic [ADDR_W-1:0] p_addr = '0;
    logic [DATA_W-1:0] tdc_base = '0;
    logic [ADDR_W-1:0] got_addr[$];
    logic [DATA_W-1:0] got_data[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // TDC model: data is only valid once RDN has been low for the full pulse width.
    task automatic sample_pre();
        if (RDN === 1'b0) begin
            rd_run++;
        end else begin
            if (p_rdn === 1'b0 && rd_run != RD_PULSE) len_bad++;
            rd_run = 0;
        end
        if (RDN === 1'b0 && rd_run == RD_PULSE)
            data_in = tdc_base + DATA_W'(addr);
        else
            data_in = ~(tdc_base + DATA_W'(addr));
        if (RDN === 1'b0 && p_rdn === 1'b1) begin
            rdn_falls++;
            if (!(p_csn === 1'b0 && p2_csn === 1'b1)) lead_bad++;
        end
        if (RDN === 1'b0 && CSN !== 1'b0) lead_bad++;
        if (res_valid === 1'b1 && (CSN === 1'b0 || RDN === 1'b0)) ovl_bad++;
        if (CSN === 1'b0) csn_low++;
        if (done === 1'b1) done_cnt++;
        if (timeout === 1'b1) to_cnt++;
        if (p_valid === 1'b1 && p_ready !== 1'b1 &&
            (res_valid !== 1'b1 || res_data !== p_data || res_addr !== p_addr)) stab_bad++;
        if (res_valid === 1'b1 && res_ready === 1'b1) begin
            got_addr.push_back(res_addr);
            got_data.push_back(res_data);
        end
        p2_csn  = p_csn;
        p_csn   = CSN;
        p_rdn   = RDN;
        p_valid = res_valid;
        p_ready = res_ready;
        p_data  = res_data;
        p_addr  = res_addr;
    endtask

    task automatic tick();
        sample_pre();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Expected block: NUM_RES consecutive registers starting at RES_BASE, data = base + address.
    task automatic check_words(input int start, input logic [DATA_W-1:0] base);
        check("word_count", 64'(got_addr.size() - start), 64'(NUM_RES));
        for (int i = 0; i < NUM_RES; i++) begin
            if (start + i < got_addr.size()) begin
                check("word_addr", 64'(got_addr[start + i]), 64'(ADDR_W'(RES_BASE + i)));
                check("word_data", 64'(got_data[start + i]), 64'(DATA_W'(base + DATA_W'(RES_BASE + i))));
            end
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int j;
        j = 0;
        while (done !== 1'b1 && j < budget) begin
            tick();
            j++;
        end
        check(tag, 64'(j < budget), 64'd1);
    endtask

    task automatic wait_csn_low(input string tag, output int k);
        k = 0;
        while (CSN !== 1'b0 && k < 50) begin
            tick();
            k++;
        end
        check(tag, 64'(k < 50), 64'd1);
    endtask

    initial begin
        int k, j, start, s_falls, s_csn, s_len, s_lead, s_ovl, s_stab, s_done, s_to;

        // Reset state
        ticks(5);
        check("rst_csn", 64'(CSN), 64'd1);
        check("rst_rdn", 64'(RDN), 64'd1);
        check("rst_valid", 64'(res_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_addr", 64'(addr), 64'd0);
        check("rst_done_to", 64'({done, timeout}), 64'd0);
        check("rst_res", 64'({res_data, res_addr}), 64'd0);
        reset = 1'b0;
        ticks(2);

        // Basic read, res_ready held high
        tdc_base = 28'h0000100;
        start = got_addr.size();
        s_falls = rdn_falls; s_len = len_bad; s_lead = lead_bad; s_ovl = ovl_bad; s_done = done_cnt;
        arm = 1'b1; tick(); arm = 1'b0;
        check("arm_busy", 64'(busy), 64'd1);
        check("arm_csn", 64'(CSN), 64'd1);
        intn = 1'b0;
        wait_csn_low("basic_setup_seen", k);
        check("int_to_setup_latency", 64'(k), 64'd3);
        check("setup_rdn", 64'(RDN), 64'd1);
        check("setup_addr", 64'(addr), 64'(RES_BASE));
        intn = 1'b1;
        j = 0;
        while (done !== 1'b1 && j < 200) begin
            tick();
            j++;
        end
        check("setup_to_done", 64'(j), 64'd24);
        tick();
        check("after_done_busy", 64'(busy), 64'd0);
        check("after_done_done", 64'(done), 64'd0);
        check("basic_rdn_pulses", 64'(rdn_falls - s_falls), 64'(NUM_RES));
        check("basic_rdn_len", 64'(len_bad - s_len), 64'd0);
        check("basic_csn_lead", 64'(lead_bad - s_lead), 64'd0);
        check("basic_overlap", 64'(ovl_bad - s_ovl), 64'd0);
        check("basic_done_pulses", 64'(done_cnt - s_done), 64'd1);
        check_words(start, tdc_base);

        // Backpressure on the first word
        tdc_base = DATA_W'($urandom_range(0, 28'h7ffffff));
        start = got_addr.size();
        s_falls = rdn_falls; s_stab = stab_bad;
        res_ready = 1'b0;
        arm = 1'b1; tick(); arm = 1'b0;
        intn = 1'b0;
        k = 0;
        while (res_valid !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        check("bp_valid_seen", 64'(k < 50), 64'd1);
        intn = 1'b1;
        s_csn = csn_low;
        ticks(10);
        check("bp_valid_held", 64'(res_valid), 64'd1);
        check("bp_data", 64'(res_data), 64'(DATA_W'(tdc_base + DATA_W'(RES_BASE))));
        check("bp_addr", 64'(res_addr), 64'(RES_BASE));
        check("bp_csn_idle", 64'(csn_low - s_csn), 64'd0);
        check("bp_no_extra_rdn", 64'(rdn_falls - s_falls), 64'd1);
        res_ready = 1'b1;
        wait_done("bp_done", 200);
        tick();
        check("bp_stable", 64'(stab_bad - s_stab), 64'd0);
        check("bp_rdn_pulses", 64'(rdn_falls - s_falls), 64'(NUM_RES));
        check_words(start, tdc_base);

        // Randomized ready and data
        for (int r = 0; r < 3; r++) begin
            tdc_base = DATA_W'($urandom_range(0, 28'h7ffffff));
            start = got_addr.size();
            s_stab = stab_bad; s_ovl = ovl_bad; s_len = len_bad; s_lead = lead_bad;
            arm = 1'b1; tick(); arm = 1'b0;
            intn = 1'b0;
            ticks($urandom_range(1, 4));
            intn = 1'b1;
            j = 0;
            while (done !== 1'b1 && j < 600) begin
                res_ready = 1'($urandom_range(0, 1));
                tick();
                j++;
            end
            check("rnd_done", 64'(j < 600), 64'd1);
            res_ready = 1'b1;
            tick();
            check("rnd_busy_low", 64'(busy), 64'd0);
            check("rnd_protocol", 64'((stab_bad - s_stab) + (ovl_bad - s_ovl) + (len_bad - s_len) + (lead_bad - s_lead)), 64'd0);
            check_words(start, tdc_base);
        end

        // Ignored events: intn glitch in IDLE, arm pulses during readout
        s_csn = csn_low;
        intn = 1'b0; tick(); intn = 1'b1;
        ticks(4);
        check("glitch_idle_busy", 64'(busy), 64'd0);
        arm = 1'b1; tick(); arm = 1'b0;
        ticks(20);
        check("glitch_not_latched_busy", 64'(busy), 64'd1);
        check("glitch_not_latched_bus", 64'(csn_low - s_csn), 64'd0);
        tdc_base = DATA_W'($urandom_range(0, 28'h7ffffff));
        start = got_addr.size();
        s_falls = rdn_falls;
        intn = 1'b0;
        wait_csn_low("ign_setup_seen", k);
        intn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            arm = (i % 3 == 0);
            tick();
        end
        arm = 1'b0;
        wait_done("ign_done", 200);
        check("ign_busy_in_done", 64'(busy), 64'd1);
        tick();
        check("ign_busy_after", 64'(busy), 64'd0);
        s_csn = csn_low;
        intn = 1'b0;
        ticks(10);
        intn = 1'b1;
        check("ign_no_queued_arm", 64'(csn_low - s_csn), 64'd0);
        check("ign_still_idle", 64'(busy), 64'd0);
        check("ign_rdn_pulses", 64'(rdn_falls - s_falls), 64'(NUM_RES));
        check_words(start, tdc_base);
        ticks(3);

        // Reset during STROBE of the second word
        tdc_base = DATA_W'($urandom_range(0, 28'h7ffffff));
        start = got_addr.size();
        arm = 1'b1; tick(); arm = 1'b0;
        intn = 1'b0;
        k = 0;
        while (!(RDN === 1'b0 && addr === ADDR_W'(RES_BASE + 1)) && k < 100) begin
            tick();
            k++;
        end
        check("mid_strobe_reached", 64'(k < 100), 64'd1);
        reset = 1'b1; tick(); reset = 1'b0;
        check("mid_rst_csn", 64'(CSN), 64'd1);
        check("mid_rst_rdn", 64'(RDN), 64'd1);
        check("mid_rst_valid", 64'(res_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_words", 64'(got_addr.size() - start), 64'd1);
        intn = 1'b1;
        ticks(3);
        tdc_base = DATA_W'($urandom_range(0, 28'h7ffffff));
        start = got_addr.size();
        s_len = len_bad; s_lead = lead_bad;
        arm = 1'b1; tick(); arm = 1'b0;
        intn = 1'b0;
        wait_csn_low("rerun_setup_seen", k);
        intn = 1'b1;
        wait_done("rerun_done", 200);
        tick();
        check("rerun_protocol", 64'((len_bad - s_len) + (lead_bad - s_lead)), 64'd0);
        check_words(start, tdc_base);

        // Interrupt never arrives
        s_csn = csn_low; s_to = to_cnt;
        arm = 1'b1; tick(); arm = 1'b0;
`ifdef TDC_RD_TIMEOUT_EN
        j = 0;
        while (timeout !== 1'b1 && j < TIMEOUT + 100) begin
            tick();
            j++;
        end
        check("timeout_latency", 64'(j), 64'(TIMEOUT));
        check("timeout_busy", 64'(busy), 64'd0);
        tick();
        check("timeout_one_pulse", 64'(timeout), 64'd0);
        check("timeout_count", 64'(to_cnt - s_to), 64'd1);
`else
        ticks(TIMEOUT + 100);
        check("no_timeout_busy", 64'(busy), 64'd1);
        check("no_timeout_pulse", 64'(to_cnt - s_to), 64'd0);
`endif
        check("wait_no_bus", 64'(csn_low - s_csn), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
